// File: rtl/seq_mult_controller.sv
// Multi-cycle shift-and-add multiplier for sign-magnitude operands. The
// result and its sign are held between completions for the display decoders.
module seq_mult_controller #(
  parameter int MAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*MAG_W+1:0] operands,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*MAG_W-1:0] result,
  output logic               sign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [MAG_W-1:0]   mcand_r, mplier_r, cnt_r, mshift_s;
  logic               sl_r, sr_r, done_r, sign_r;
  logic [2*MAG_W-1:0] acc_r, acc_nxt_s, addend_s, result_r;
  logic               capture_s, last_s;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; a start in DONE re-enters CALC with no idle cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = CALC;
        else       state_nxt_s = IDLE;
      end
      CALC: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = CALC;
      end
      DONE: begin
        if (start) state_nxt_s = CALC;
        else       state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // output decode; status flags are decoded from the state register only
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    case (state_r)
      IDLE:    ready = 1'b1;
      CALC:    busy  = 1'b1;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // partial-product step for the multiplier bit selected by cnt
  always_comb begin
    capture_s = 1'b0;
    if (start && (state_r == IDLE || state_r == DONE)) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
    mshift_s = mplier_r >> cnt_r;
    last_s   = (cnt_r == MAG_W'(MAG_W - 1));
    addend_s = {{MAG_W{1'b0}}, mcand_r} << cnt_r;
    if (mshift_s[0]) begin
      acc_nxt_s = acc_r + addend_s;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // datapath: operand capture, accumulation and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {MAG_W{1'b0}};
      mplier_r <= {MAG_W{1'b0}};
      sl_r     <= 1'b0;
      sr_r     <= 1'b0;
      acc_r    <= {(2*MAG_W){1'b0}};
      cnt_r    <= {MAG_W{1'b0}};
      result_r <= {(2*MAG_W){1'b0}};
      sign_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (capture_s) begin
        mcand_r  <= operands[2*MAG_W:MAG_W+1];
        sl_r     <= operands[2*MAG_W+1];
        mplier_r <= operands[MAG_W-1:0];
        sr_r     <= operands[MAG_W];
        acc_r    <= {(2*MAG_W){1'b0}};
        cnt_r    <= {MAG_W{1'b0}};
      end else if (state_r == CALC) begin
        acc_r <= acc_nxt_s;
        cnt_r <= cnt_r + MAG_W'(1);
        if (last_s) begin
          result_r <= acc_nxt_s;
          // a zero magnitude is always shown as positive
          sign_r   <= (sl_r ^ sr_r) & (acc_nxt_s != {(2*MAG_W){1'b0}});
          done_r   <= 1'b1;
        end else begin
          done_r <= 1'b0;
        end
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign done   = done_r;
  assign result = result_r;
  assign sign   = sign_r;

endmodule

// File: tb/tb_seq_mult_controller.sv
// Scoreboard bench for seq_mult_controller: the driver queues the expected
// product and completion edge, a negedge monitor checks every done pulse.
module tb_seq_mult_controller;
  localparam int MAG_W = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, ready, busy, done, sign;
  logic [9:0] operands;
  logic [7:0] result;

  typedef struct {
    logic [7:0] res;
    logic       sg;
    int         at;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  seq_mult_controller #(.MAG_W(MAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operands(operands),
    .ready(ready), .busy(busy), .done(done), .result(result), .sign(sign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done actual=1 required=0 (edge %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("result", {24'd0, result}, {24'd0, e.res});
        chk("sign", {31'd0, sign}, {31'd0, e.sg});
        chk("done_edge", cyc, e.at);
      end
    end
  end

  // called at a negedge; returns at the negedge right after acceptance
  task automatic issue(input logic [4:0] l, input logic [4:0] r,
                       input logic [7:0] res, input logic sg);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
    start    = 1'b1;
    operands = {l, r};
    q.push_back('{res, sg, cyc + 1 + MAG_W});
    @(negedge clk);
    start    = 1'b0;
    operands = 10'h3FF;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    operands = 10'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_sign", {31'd0, sign}, 32'd0);

    // 1: +3 x -5
    issue(5'b00011, 5'b10101, 8'h0F, 1'b1);
    chk("calc_busy", {31'd0, busy}, 32'd1);
    chk("calc_ready", {31'd0, ready}, 32'd0);
    drain();
    chk("hold_result", {24'd0, result}, 32'h0F);
    chk("hold_sign", {31'd0, sign}, 32'd1);

    // 2: maximum magnitudes, both sign combinations
    issue(5'b11111, 5'b11111, 8'hE1, 1'b0);
    drain();
    issue(5'b01111, 5'b01111, 8'hE1, 1'b0);
    drain();

    // 3: zero rule
    issue(5'b10000, 5'b10111, 8'h00, 1'b0);
    drain();
    issue(5'b10110, 5'b00000, 8'h00, 1'b0);
    drain();
    issue(5'b01001, 5'b11101, 8'h75, 1'b1);
    drain();

    // 4: back-to-back, second start presented in DONE
    issue(5'b00111, 5'b10011, 8'h15, 1'b1);
    issue(5'b00010, 5'b00110, 8'h0C, 1'b0);
    drain();

    // 5: start during CALC is ignored
    issue(5'b00101, 5'b00101, 8'h19, 1'b0);
    @(negedge clk);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    start    = 1'b1;
    operands = {5'b11001, 5'b01001};
    @(negedge clk);
    start = 1'b0;
    drain();

    // 6: asynchronous reset in the 3rd CALC cycle
    issue(5'b01101, 5'b11011, 8'h8F, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", {24'd0, result}, 32'd0);
    chk("arst_sign", {31'd0, sign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    chk("post_rst_result", {24'd0, result}, 32'd0);
    issue(5'b00001, 5'b00001, 8'h01, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
